decoder_nto2n_scan: RTL



---
 rtl/decoder_pkg.sv | 27 ++
 rtl/dwell_counter.sv | 31 +++
 rtl/decoder_nto2n_scan.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the N-to-2^N decoder family.
// State encoding, mode constants and a one-hot helper sized for up to 64 lines.
package decoder_pkg;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select supported by the decoder family (2^6 = 64 lines).
    localparam int MAX_N = 6;

    // One-hot of idx within a field of 'width' lines; all-zero if idx is out of range.
    function automatic logic [63:0] onehot(input logic [MAX_N-1:0] idx, input int width);
        logic [63:0] r;
        r = '0;
        if (int'(idx) < width) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while run is high and flags the last count.
// clr has priority over run. With DWELL=1 tick is permanently high.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    // Count register: clear, or step and roll over after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N one-hot decoder with enable and a dwell-timed scan mode.
// Optional break-before-make blanking in scan mode: define DECODER_SCAN_BLANK_EN.
// fsm_state exposes the controller state for observation.
module decoder_nto2n_scan
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     i,
    input  logic             load,
    output logic [2**N-1:0]  d,
    output logic [N-1:0]     sel,
    output logic             wrap,
    output logic [1:0]       fsm_state
);

    localparam int W = 2**N;
    localparam logic [N-1:0] IDX_MAX = N'(W - 1);

`ifdef DECODER_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    state_t         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d, idx_inc;
    logic [W-1:0]   d_q, d_d;
    logic           wrap_q, wrap_d;
    logic           cnt_clr, cnt_run, tick;

    assign idx_inc   = idx_q + N'(1);
    assign d         = d_q;
    assign sel       = idx_q;
    assign wrap      = wrap_q;
    assign fsm_state = state_q;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .run   (cnt_run),
        .tick  (tick)
    );

    // Next state: en and mode are sampled every edge; en low wins.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_OFF;
        end else if (mode == MODE_SCAN) begin
            state_d = S_SCAN;
        end else begin
            state_d = S_DIRECT;
        end
    end

    // Next index/output values, decided by the state being entered.
    always_comb begin
        idx_d   = idx_q;
        d_d     = d_q;
        wrap_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_run = 1'b0;
        case (state_d)
            S_OFF: begin
                // sel holds; outputs dark, dwell count parked at zero.
                d_d     = '0;
                cnt_clr = 1'b1;
            end
            S_DIRECT: begin
                idx_d   = i;
                d_d     = W'(onehot(MAX_N'(i), W));
                cnt_clr = 1'b1;
            end
            S_SCAN: begin
                if (state_q != S_SCAN || load) begin
                    // Entry or reload: restart the dwell at index i, never a wrap.
                    idx_d   = i;
                    cnt_clr = 1'b1;
                    d_d     = BLANK ? '0 : W'(onehot(MAX_N'(i), W));
                end else begin
                    cnt_run = 1'b1;
                    if (tick) begin
                        idx_d  = idx_inc;
                        d_d    = BLANK ? '0 : W'(onehot(MAX_N'(idx_inc), W));
                        wrap_d = (idx_q == IDX_MAX);
                    end else if (BLANK && d_q == '0) begin
                        // End of the blank gap: light the already-selected line.
                        d_d = W'(onehot(MAX_N'(idx_q), W));
                    end
                end
            end
            default: begin
                d_d     = '0;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State and output registers; reset clears all outputs asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            idx_q   <= '0;
            d_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule
